// File: rtl/binary_patch_extractor_3x3_if.sv
// Pixel-in / patch-out bundle for binary_patch_extractor_3x3.
// The master drives the raster pixel stream; the slave (the extractor) drives the patch outputs.
interface binary_patch_extractor_3x3_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
);
    // Handshake: a pixel is transferred on every rising clk edge where pix_valid is high.
    // There is no ready in either direction; patch_valid marks a one-cycle result.
    logic          pix_valid;
    logic          pix_bit;
    logic          sof;
    logic [8:0]    patch_bits;
    logic          patch_valid;
    logic [RW-1:0] patch_row;
    logic [CW-1:0] patch_col;
    logic          frame_done;
    logic          sof_err;

    modport master (
        output pix_valid, pix_bit, sof,
        input  patch_bits, patch_valid, patch_row, patch_col, frame_done, sof_err
    );

    modport slave (
        input  pix_valid, pix_bit, sof,
        output patch_bits, patch_valid, patch_row, patch_col, frame_done, sof_err
    );
endinterface

// File: rtl/binary_patch_extractor_3x3.sv
// Raster-scan 1-bit pixel stream to registered 3x3 windows (no padding, stride 1).
// Optional start-of-frame checking is compiled in with PATCH_SOF_CHECK_EN.
module binary_patch_extractor_3x3 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input logic clk,
    input logic reset,
    binary_patch_extractor_3x3_if.slave bus
);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [IMG_W-1:0] lb1;
    logic [IMG_W-1:0] lb2;
    logic [8:0]       win;

    logic [8:0]       patch_bits_q;
    logic             patch_valid_q;
    logic [RW-1:0]    patch_row_q;
    logic [CW-1:0]    patch_col_q;
    logic             frame_done_q;
    logic             sof_err_q;

    logic             resync;
    logic [CW-1:0]    eff_col;
    logic [RW-1:0]    eff_row;
    logic [8:0]       win_next;
    logic             emit;
    logic             last;

    always_comb begin
        resync = 1'b0;
`ifdef PATCH_SOF_CHECK_EN
        resync = bus.sof && ((row != '0) || (col != '0));
`endif
        // A misplaced sof pixel is handled as if it were the first pixel of a frame.
        eff_row  = resync ? '0 : row;
        eff_col  = resync ? '0 : col;
        // Shift the window left; the new right column is {lb2, lb1, pixel} top to bottom.
        win_next = {bus.pix_bit, win[8:7], lb1[eff_col], win[5:4], lb2[eff_col], win[2:1]};
        emit     = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
        last     = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col           <= '0;
            row           <= '0;
            lb1           <= '0;
            lb2           <= '0;
            win           <= '0;
            patch_bits_q  <= '0;
            patch_valid_q <= 1'b0;
            patch_row_q   <= '0;
            patch_col_q   <= '0;
            frame_done_q  <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            patch_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (bus.pix_valid) begin
                win          <= win_next;
                lb2[eff_col] <= lb1[eff_col];
                lb1[eff_col] <= bus.pix_bit;
                if (resync) begin
                    sof_err_q <= 1'b1;
                end
                if (emit) begin
                    patch_bits_q  <= win_next;
                    patch_valid_q <= 1'b1;
                    patch_row_q   <= eff_row - RW'(2);
                    patch_col_q   <= eff_col - CW'(2);
                    frame_done_q  <= last;
                end
                if (eff_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
            end
        end
    end

    assign bus.patch_bits  = patch_bits_q;
    assign bus.patch_valid = patch_valid_q;
    assign bus.patch_row   = patch_row_q;
    assign bus.patch_col   = patch_col_q;
    assign bus.frame_done  = frame_done_q;

`ifdef PATCH_SOF_CHECK_EN
    assign bus.sof_err = sof_err_q;
`else
    // Without checking, sof is ignored and the error flag can never set.
    logic unused_sof;
    logic unused_err;
    assign unused_sof  = bus.sof;
    assign unused_err  = sof_err_q;
    assign bus.sof_err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_patch_extractor_3x3.sv
// Bench for binary_patch_extractor_3x3: a 4x4 and an 8x8 instance share clock and reset;
// a pixel-image model predicts every patch and its arrival cycle.
module tb_binary_patch_extractor_3x3;

`ifdef PATCH_SOF_CHECK_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif
    localparam int W = 48;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] cyc = '0;

    binary_patch_extractor_3x3_if #(.IMG_W(4), .IMG_H(4)) bus4 ();
    binary_patch_extractor_3x3_if #(.IMG_W(8), .IMG_H(8)) bus8 ();

    binary_patch_extractor_3x3 #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    binary_patch_extractor_3x3 #(.IMG_W(8), .IMG_H(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int checks = 0;
    int failures = 0;

    // entry = {arrival cycle[31:0], frame_done, row[2:0], col[2:0], bits[8:0]}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q4[$];
    int  mr[2];
    int  mc[2];
    bit  img[2][8][8];
    bit  exp_err[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_pixel(input int d, input bit p, input bit s);
        int sz;
        logic [8:0] b;
        logic [W-1:0] e;
        bit fd;
        sz = (d == 1) ? 8 : 4;
        if (SOF_EN && s && (mr[d] != 0 || mc[d] != 0)) begin
            exp_err[d] = 1'b1;
            mr[d] = 0;
            mc[d] = 0;
        end
        img[d][mr[d]][mc[d]] = p;
        if (mr[d] >= 2 && mc[d] >= 2) begin
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    b[3*ky+kx] = img[d][mr[d]-2+ky][mc[d]-2+kx];
            fd = (mr[d] == sz - 1) && (mc[d] == sz - 1);
            e = {cyc + 32'd1, fd, 3'(mr[d] - 2), 3'(mc[d] - 2), b};
            if (d == 1) exp_q.push_back(e);
            else exp_q4.push_back(e);
        end
        if (mc[d] == sz - 1) begin
            mc[d] = 0;
            mr[d] = (mr[d] == sz - 1) ? 0 : mr[d] + 1;
        end else begin
            mc[d] = mc[d] + 1;
        end
    endtask

    // driver: one clock per call, d selects the instance receiving the pixel
    task automatic step(input int d, input bit pv, input bit p, input bit s);
        @(negedge clk);
        bus4.pix_valid = pv && (d == 0);
        bus4.pix_bit   = p;
        bus4.sof       = s;
        bus8.pix_valid = pv && (d == 1);
        bus8.pix_bit   = p;
        bus8.sof       = s;
        if (pv) model_pixel(d, p, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_bits8"},  64'(bus8.patch_bits),  64'd0);
        check({tag, "_valid8"}, 64'(bus8.patch_valid), 64'd0);
        check({tag, "_rc8"},    64'({bus8.patch_row, bus8.patch_col}), 64'd0);
        check({tag, "_fd8"},    64'(bus8.frame_done),  64'd0);
        check({tag, "_err8"},   64'(bus8.sof_err),     64'd0);
        check({tag, "_out4"},   64'({bus4.patch_bits, bus4.patch_valid, bus4.frame_done}), 64'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bus4.pix_valid = 1'b0;
        bus8.pix_valid = 1'b0;
        #1;
        check_zero_outputs("in_reset");
        repeat (n) @(negedge clk);
        check_zero_outputs("end_reset");
        check("q8_at_reset", 64'(exp_q.size()), 64'd0);
        check("q4_at_reset", 64'(exp_q4.size()), 64'd0);
        exp_q.delete();
        exp_q4.delete();
        for (int d = 0; d < 2; d++) begin
            mr[d] = 0;
            mc[d] = 0;
            exp_err[d] = 1'b0;
        end
        reset = 1'b0;
    endtask

    // scoreboard: pop on every patch; an expected entry whose cycle has passed is a miss
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0][47:16] < cyc) begin
                check("miss8", 64'd0, 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            while (exp_q4.size() > 0 && exp_q4[0][47:16] < cyc) begin
                check("miss4", 64'd0, 64'(exp_q4[0]));
                void'(exp_q4.pop_front());
            end
            if (bus8.patch_valid) begin
                if (exp_q.size() == 0) check("unexpected8", 64'd1, 64'd0);
                else check("patch8",
                           64'({cyc, bus8.frame_done, bus8.patch_row, bus8.patch_col, bus8.patch_bits}),
                           64'(exp_q.pop_front()));
            end
            if (bus4.patch_valid) begin
                if (exp_q4.size() == 0) check("unexpected4", 64'd1, 64'd0);
                else check("patch4",
                           64'({cyc, bus4.frame_done, 1'b0, bus4.patch_row, 1'b0, bus4.patch_col, bus4.patch_bits}),
                           64'(exp_q4.pop_front()));
            end
        end
    end

    initial begin
        bus4.pix_valid = 1'b0; bus4.pix_bit = 1'b0; bus4.sof = 1'b0;
        bus8.pix_valid = 1'b0; bus8.pix_bit = 1'b0; bus8.sof = 1'b0;
        repeat (2) @(negedge clk);
        do_reset(2);

        // all-ones 4x4 frame
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b1, i == 0);
        idle(2);

        // checkerboard, continuous
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                step(1, 1'b1, 1'((r + c) & 1), (r == 0) && (c == 0));
        idle(2);

        // checkerboard with random gaps
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                while ($urandom_range(1, 0) == 1) idle(1);
                step(1, 1'b1, 1'((r + c) & 1), (r == 0) && (c == 0));
            end
        idle(2);

        // all-0 then all-1, back-to-back
        for (int i = 0; i < 128; i++) step(1, 1'b1, i >= 64, (i % 64) == 0);
        idle(2);

        // reset after pixel (3,5), then a full all-1 frame
        for (int i = 0; i <= 3 * 8 + 5; i++) step(1, 1'b1, 1'b1, i == 0);
        idle(1);
        do_reset(2);
        for (int i = 0; i < 64; i++) step(1, 1'b1, 1'b1, i == 0);
        idle(2);

        // sof at (2,3), then 64 random pixels starting from that one
        for (int i = 0; i < 2 * 8 + 3; i++) step(1, 1'b1, 1'($urandom_range(1, 0)), i == 0);
        step(1, 1'b1, 1'($urandom_range(1, 0)), 1'b1);
        idle(1);
        check("sof_err_next", 64'(bus8.sof_err), 64'(exp_err[1]));
        for (int i = 0; i < 63; i++) step(1, 1'b1, 1'($urandom_range(1, 0)), 1'b0);
        idle(3);
        check("sof_err_end", 64'(bus8.sof_err), 64'(exp_err[1]));
        check("sof_err4", 64'(bus4.sof_err), 64'(exp_err[0]));
        check("q8_empty", 64'(exp_q.size()), 64'd0);
        check("q4_empty", 64'(exp_q4.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
